fft16_stage_ctrl: RTL and testbench

- Sequencer for the pipelined radix-2 butterfly in the 16-point FFT datapath.
- Runs a full in-place-style DIT transform as 4 stages of 8 butterflies over a ping-pong sample buffer (bank 0 / bank 1).
- Per butterfly it issues read addresses and the twiddle index, then issues the matching write addresses after a fixed pipeline delay.
- Handles start/busy/done with the system and drains the pipeline between stages.

---
 rtl/fft16_stage_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_fft16_stage_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft16_stage_ctrl.sv
// fft16_stage_ctrl: stage/butterfly sequencer for the 16-point radix-2 DIT FFT.
// Optional macro FFT16_CTRL_BITREV_EN: bit-reverse stage-0 read addresses.

module fft16_stage_ctrl #(
    parameter int BF_LATENCY = 4,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        stage,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [2:0]        tw_idx,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [ADDR_W-1:0] wr_addr1
);
    localparam int L = RD_LATENCY + BF_LATENCY;

`ifdef FFT16_CTRL_BITREV_EN
    localparam bit BITREV = 1'b1;
`else
    localparam bit BITREV = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            st;
    logic [2:0]        bcnt;
    logic [7:0]        dcnt;

    logic              go;
    logic [1:0]        ns;
    logic [2:0]        nb;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] grp;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] na0;
    logic [ADDR_W-1:0] na1;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [2:0]        ntw;
    logic [ADDR_W-1:0] src0;
    logic [ADDR_W-1:0] src1;

    logic [L-1:0]      dly_en;
    logic [L-1:0]      dly_bank;
    logic [ADDR_W-1:0] dly_a0 [L];
    logic [ADDR_W-1:0] dly_a1 [L];

    function automatic logic [ADDR_W-1:0] rev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    // Decide whether a butterfly issues next cycle, and which one
    always_comb begin
        go = 1'b0;
        ns = stage;
        nb = 3'd0;
        unique case (st)
            IDLE, DONE: begin
                go = start;
                ns = 2'd0;
            end
            ISSUE: begin
                go = (bcnt != 3'd7);
                nb = bcnt + 3'd1;
            end
            DRAIN: begin
                go = (dcnt == 8'(L - 1)) && (stage != 2'd3);
                ns = stage + 2'd1;
            end
            default: ;
        endcase
    end

    // Operand addresses and twiddle index of the next butterfly
    always_comb begin
        span = ADDR_W'(1) << ns;
        grp  = ADDR_W'(nb) >> ns;
        pos  = ADDR_W'(nb) & (span - ADDR_W'(1));
        na0  = (grp << ({1'b0, ns} + 3'd1)) | pos;
        na1  = na0 + span;
        ntw  = pos[2:0] << (2'd3 - ns);
        ra0  = na0;
        ra1  = na1;
        if (BITREV && ns == 2'd0) begin
            ra0 = rev(na0);
            ra1 = rev(na1);
        end
    end

    // Write addresses always use natural order; undo any read reversal
    always_comb begin
        src0 = rd_addr0;
        src1 = rd_addr1;
        if (BITREV && stage == 2'd0) begin
            src0 = rev(rd_addr0);
            src1 = rev(rd_addr1);
        end
    end

    // Control FSM with registered read-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            bcnt     <= 3'd0;
            dcnt     <= 8'd0;
            stage    <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_bank  <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_idx   <= 3'd0;
        end else begin
            done     <= 1'b0;
            rd_en    <= go;
            rd_addr0 <= go ? ra0 : '0;
            rd_addr1 <= go ? ra1 : '0;
            tw_idx   <= go ? ntw : 3'd0;
            unique case (st)
                IDLE, DONE: begin
                    st <= IDLE;
                    if (start) begin
                        st      <= ISSUE;
                        stage   <= 2'd0;
                        bcnt    <= 3'd0;
                        busy    <= 1'b1;
                        rd_bank <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (bcnt == 3'd7) begin
                        st   <= DRAIN;
                        dcnt <= 8'd0;
                    end else begin
                        bcnt <= bcnt + 3'd1;
                    end
                end
                DRAIN: begin
                    if (dcnt == 8'(L - 1)) begin
                        if (stage == 2'd3) begin
                            st      <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            stage   <= 2'd0;
                            rd_bank <= 1'b0;
                        end else begin
                            st      <= ISSUE;
                            stage   <= ns;
                            bcnt    <= 3'd0;
                            rd_bank <= ns[0];
                        end
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Delay line carrying each read to its write slot L cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_en   <= '0;
            dly_bank <= '0;
            for (int i = 0; i < L; i++) begin
                dly_a0[i] <= '0;
                dly_a1[i] <= '0;
            end
        end else begin
            dly_en   <= {dly_en[L-2:0], rd_en};
            dly_bank <= {dly_bank[L-2:0], rd_en & ~rd_bank};
            dly_a0[0] <= src0;
            dly_a1[0] <= src1;
            for (int i = 1; i < L; i++) begin
                dly_a0[i] <= dly_a0[i-1];
                dly_a1[i] <= dly_a1[i-1];
            end
        end
    end

    assign wr_en    = dly_en[L-1];
    assign wr_bank  = dly_bank[L-1];
    assign wr_addr0 = dly_a0[L-1];
    assign wr_addr1 = dly_a1[L-1];

endmodule

// File: tb/tb_fft16_stage_ctrl.sv
// tb_fft16_stage_ctrl: self-checking bench for the FFT stage sequencer.
// Cycle model predicts read side; write side is checked via a queue.

module tb_fft16_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [1:0] stage;
    logic       rd_en;
    logic       rd_bank;
    logic [3:0] rd_addr0;
    logic [3:0] rd_addr1;
    logic [2:0] tw_idx;
    logic       wr_en;
    logic       wr_bank;
    logic [3:0] wr_addr0;
    logic [3:0] wr_addr1;

    int total = 0;
    int bad = 0;
    int now = 0;
    int m_cnt = 0;

    logic       exp_rd_en;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_rd_bank;
    logic [1:0] exp_stage;
    logic [3:0] exp_a0;
    logic [3:0] exp_a1;
    logic [2:0] exp_tw;

    typedef struct {
        int         cyc;
        logic [3:0] a0;
        logic [3:0] a1;
        logic       bank;
    } wr_t;

    wr_t sb[$];

    fft16_stage_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_bank  (rd_bank),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_idx   (tw_idx),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rev4(input logic [3:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic model_addr(input int s, input int b,
                              output logic [3:0] r0, output logic [3:0] r1,
                              output logic [2:0] tw,
                              output logic [3:0] n0, output logic [3:0] n1);
        int span;
        int x0;
        span = 1 << s;
        x0 = (b / span) * 2 * span + (b % span);
        n0 = 4'(x0);
        n1 = 4'(x0 + span);
        tw = 3'((b % span) * (8 / span));
        r0 = n0;
        r1 = n1;
`ifdef FFT16_CTRL_BITREV_EN
        if (s == 0) begin
            r0 = rev4(n0);
            r1 = rev4(n1);
        end
`endif
    endtask

    // Cycle-level model: run index 1..52 busy, 53 done
    always @(posedge clk) begin : model
        logic [3:0] r0, r1, n0, n1;
        logic [2:0] tw;
        int s, k;
        wr_t w;
        now = now + 1;
        if (!rst_n) m_cnt = 0;
        else if (m_cnt == 0 || m_cnt == 53) m_cnt = start ? 1 : 0;
        else m_cnt = m_cnt + 1;
        exp_rd_en = 1'b0;
        exp_busy = 1'b0;
        exp_rd_bank = 1'b0;
        exp_stage = 2'd0;
        exp_a0 = 4'd0;
        exp_a1 = 4'd0;
        exp_tw = 3'd0;
        exp_done = (m_cnt == 53);
        if (m_cnt >= 1 && m_cnt <= 52) begin
            s = (m_cnt - 1) / 13;
            k = (m_cnt - 1) % 13;
            exp_busy = 1'b1;
            exp_stage = s[1:0];
            exp_rd_bank = s[0];
            if (k < 8) begin
                model_addr(s, k, r0, r1, tw, n0, n1);
                exp_rd_en = 1'b1;
                exp_a0 = r0;
                exp_a1 = r1;
                exp_tw = tw;
                w.cyc = now + 5;
                w.a0 = n0;
                w.a1 = n1;
                w.bank = ~s[0];
                sb.push_back(w);
            end
        end
    end

    // Write-side scoreboard
    always @(negedge clk) begin : wr_mon
        wr_t w;
        if (rst_n) begin
            total++;
            if (wr_en) begin
                if (sb.size() == 0 || sb[0].cyc != now) begin
                    bad++;
                    $display("FAIL wr_unexpected cyc=%0d got=%h/%h due=%0d",
                             now, wr_addr0, wr_addr1,
                             (sb.size() == 0) ? -1 : sb[0].cyc);
                    if (sb.size() != 0 && sb[0].cyc < now) void'(sb.pop_front());
                end else begin
                    w = sb.pop_front();
                    if ({wr_addr0, wr_addr1, wr_bank} !== {w.a0, w.a1, w.bank}) begin
                        bad++;
                        $display("FAIL wr_data cyc=%0d got=%h/%h/b%0d exp=%h/%h/b%0d",
                                 now, wr_addr0, wr_addr1, wr_bank, w.a0, w.a1, w.bank);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= now) begin
                bad++;
                $display("FAIL wr_missing cyc=%0d exp=%h/%h", now, sb[0].a0, sb[0].a1);
                void'(sb.pop_front());
            end else if ({wr_addr0, wr_addr1} !== 8'h00) begin
                bad++;
                $display("FAIL wr_addr_idle cyc=%0d got=%h/%h exp=0/0", now, wr_addr0, wr_addr1);
            end
        end
    end

    task automatic pulse_start(output int t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = now;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, stage, rd_en, rd_bank} !== 6'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=0", {busy, done, stage, rd_en, rd_bank});
        end
        total++;
        if ({rd_addr0, rd_addr1, tw_idx, wr_en, wr_bank, wr_addr0, wr_addr1} !== 21'd0) begin
            bad++;
            $display("FAIL reset_addr got=%h exp=0",
                     {rd_addr0, rd_addr1, tw_idx, wr_en, wr_bank, wr_addr0, wr_addr1});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_run;
        int t0, c;
        logic [3:0] e0, e1;
        pulse_start(t0);
        for (int i = 0; i < 58; i++) begin
            @(negedge clk);
            c = now - t0;
            total++;
            if ({rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank} !==
                {exp_rd_en, exp_a0, exp_a1, exp_tw, exp_rd_bank}) begin
                bad++;
                $display("FAIL full_rd c=%0d got=%b/%h/%h/%0d/%b exp=%b/%h/%h/%0d/%b",
                         c, rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank,
                         exp_rd_en, exp_a0, exp_a1, exp_tw, exp_rd_bank);
            end
            total++;
            if ({busy, done, stage} !== {exp_busy, exp_done, exp_stage}) begin
                bad++;
                $display("FAIL full_ctl c=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                         c, busy, done, stage, exp_busy, exp_done, exp_stage);
            end
            if (c == 1) begin
                total++;
                if ({busy, rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank} !==
                    {1'b1, 1'b1, 4'd0, 4'd1, 3'd0, 1'b0}) begin
                    bad++;
                    $display("FAIL first_issue got=%b/%b/%h/%h/%0d/%b exp=1/1/0/1/0/0",
                             busy, rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank);
                end
            end
            if (c == 4) begin
`ifdef FFT16_CTRL_BITREV_EN
                e0 = 4'd6;
                e1 = 4'd14;
`else
                e0 = 4'd6;
                e1 = 4'd7;
`endif
                total++;
                if ({rd_en, rd_addr0, rd_addr1} !== {1'b1, e0, e1}) begin
                    bad++;
                    $display("FAIL s0_b3_rd got=%b/%h/%h exp=1/%h/%h",
                             rd_en, rd_addr0, rd_addr1, e0, e1);
                end
            end
            if (c == 9) begin
                total++;
                if ({wr_en, wr_addr0, wr_addr1, wr_bank} !== {1'b1, 4'd6, 4'd7, 1'b1}) begin
                    bad++;
                    $display("FAIL s0_b3_wr got=%b/%h/%h/%b exp=1/6/7/1",
                             wr_en, wr_addr0, wr_addr1, wr_bank);
                end
            end
            if (c == 19) begin
                total++;
                if ({rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank} !==
                    {1'b1, 4'd9, 4'd11, 3'd4, 1'b1}) begin
                    bad++;
                    $display("FAIL s1_b5_rd got=%b/%h/%h/%0d/%b exp=1/9/b/4/1",
                             rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank);
                end
            end
            if (c == 24) begin
                total++;
                if ({wr_en, wr_addr0, wr_addr1, wr_bank} !== {1'b1, 4'd9, 4'd11, 1'b0}) begin
                    bad++;
                    $display("FAIL s1_b5_wr got=%b/%h/%h/%b exp=1/9/b/0",
                             wr_en, wr_addr0, wr_addr1, wr_bank);
                end
            end
            if (c == 45) begin
                total++;
                if ({rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank} !==
                    {1'b1, 4'd5, 4'd13, 3'd5, 1'b1}) begin
                    bad++;
                    $display("FAIL s3_b5_rd got=%b/%h/%h/%0d/%b exp=1/5/d/5/1",
                             rd_en, rd_addr0, rd_addr1, tw_idx, rd_bank);
                end
            end
            if (c == 52) begin
                total++;
                if ({busy, wr_en, wr_addr0, wr_addr1, wr_bank} !==
                    {1'b1, 1'b1, 4'd7, 4'd15, 1'b0}) begin
                    bad++;
                    $display("FAIL last_wr got=%b/%b/%h/%h/%b exp=1/1/7/f/0",
                             busy, wr_en, wr_addr0, wr_addr1, wr_bank);
                end
            end
            if (c == 53) begin
                total++;
                if ({done, busy, wr_en} !== 3'b100) begin
                    bad++;
                    $display("FAIL done_53 got=%b/%b/%b exp=1/0/0", done, busy, wr_en);
                end
            end
        end
    endtask

    task automatic test_start_ignored;
        int t0, c, ndone, done_at;
        ndone = 0;
        done_at = -1;
        pulse_start(t0);
        for (int i = 0; i < 58; i++) begin
            @(negedge clk);
            c = now - t0;
            total++;
            if ({rd_en, rd_addr0, rd_addr1, busy, done} !==
                {exp_rd_en, exp_a0, exp_a1, exp_busy, exp_done}) begin
                bad++;
                $display("FAIL ign_cycle c=%0d got=%b/%h/%h/%b/%b exp=%b/%h/%h/%b/%b",
                         c, rd_en, rd_addr0, rd_addr1, busy, done,
                         exp_rd_en, exp_a0, exp_a1, exp_busy, exp_done);
            end
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
        end
        total++;
        if (ndone != 1 || done_at != 53) begin
            bad++;
            $display("FAIL ign_done got=%0d@%0d exp=1@53", ndone, done_at);
        end
    endtask

    task automatic test_back_to_back;
        int t0, c;
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = now;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            c = now - t0;
            total++;
            if ({rd_en, rd_addr0, rd_addr1, tw_idx, busy, done} !==
                {exp_rd_en, exp_a0, exp_a1, exp_tw, exp_busy, exp_done}) begin
                bad++;
                $display("FAIL b2b_cycle c=%0d got=%b/%h/%h/%0d/%b/%b exp=%b/%h/%h/%0d/%b/%b",
                         c, rd_en, rd_addr0, rd_addr1, tw_idx, busy, done,
                         exp_rd_en, exp_a0, exp_a1, exp_tw, exp_busy, exp_done);
            end
            if (c == 53) begin
                total++;
                if ({done, busy, rd_en} !== 3'b100) begin
                    bad++;
                    $display("FAIL b2b_done1 got=%b/%b/%b exp=1/0/0", done, busy, rd_en);
                end
            end
            if (c == 54) begin
                total++;
                if ({rd_en, busy, rd_addr0, rd_addr1} !== {1'b1, 1'b1, 4'd0, 4'd1}) begin
                    bad++;
                    $display("FAIL b2b_restart got=%b/%b/%h/%h exp=1/1/0/1",
                             rd_en, busy, rd_addr0, rd_addr1);
                end
            end
            if (c == 106) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_done2 got=%b exp=1", done);
                end
                start = 1'b0;
            end
            if (c == 108) begin
                total++;
                if ({rd_en, busy} !== 2'b00) begin
                    bad++;
                    $display("FAIL b2b_idle got=%b/%b exp=0/0", rd_en, busy);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int t0, c;
        pulse_start(t0);
        repeat (10) @(negedge clk);
        c = now - t0;
        total++;
        if ({rd_en, wr_en, busy} !== 3'b011 || c != 10) begin
            bad++;
            $display("FAIL rst_pre c=%0d got=%b/%b/%b exp=c10 0/1/1", c, rd_en, wr_en, busy);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        total++;
        if ({busy, done, stage, rd_en, rd_bank, wr_en, wr_bank} !== 8'd0) begin
            bad++;
            $display("FAIL rst_mid_ctl got=%b exp=0",
                     {busy, done, stage, rd_en, rd_bank, wr_en, wr_bank});
        end
        total++;
        if ({rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1} !== 19'd0) begin
            bad++;
            $display("FAIL rst_mid_addr got=%h exp=0",
                     {rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            total++;
            if ({wr_en, rd_en, busy} !== 3'b000) begin
                bad++;
                $display("FAIL rst_quiet i=%0d got=%b/%b/%b exp=0/0/0", i, wr_en, rd_en, busy);
            end
        end
        pulse_start(t0);
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            c = now - t0;
            total++;
            if ({rd_en, rd_addr0, rd_addr1, busy, done} !==
                {exp_rd_en, exp_a0, exp_a1, exp_busy, exp_done}) begin
                bad++;
                $display("FAIL rst_rerun c=%0d got=%b/%h/%h/%b/%b exp=%b/%h/%h/%b/%b",
                         c, rd_en, rd_addr0, rd_addr1, busy, done,
                         exp_rd_en, exp_a0, exp_a1, exp_busy, exp_done);
            end
            if (c == 53) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL rst_rerun_done got=%b exp=1", done);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
